ysyx_23060072_if_prefetch: RTL

- Instruction prefetch stage at the front of the rv32e pipeline core.
- Generates sequential fetch PCs and issues requests to instruction memory.
- Buffers returned {pc, inst} pairs in a small FIFO and presents them to decode over a valid/ready handshake.
- Handles redirects from execute by flushing the FIFO and discarding responses still in flight.

---
 rtl/ysyx_23060072_if_prefetch.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/ysyx_23060072_if_prefetch.sv
// ---------------------------------------------------------------------------
// ysyx_23060072_if_prefetch
// Instruction prefetch stage for the rv32e core. Issues sequential fetch
// requests to imem, tags them with their PC, buffers {pc, inst} pairs in a
// small FIFO and hands them to decode over valid/ready. A redirect from
// execute flushes the FIFO and discards responses still in flight.
//
// Ports:
//   clk, rst                        core clock, async active-high reset
//   imem_req_valid/ready/addr       fetch request channel (addr word aligned)
//   imem_resp_valid/data            in-order fetch response channel
//   redirect_valid/pc               branch/jump redirect from execute
//   id_valid/ready/pc/inst          decode handshake, head of FIFO
//   fifo_count                      FIFO occupancy (debug/perf)
//
// Optional macro YSYX_23060072_PREFETCH_BYPASS_EN: a live response arriving
// while the FIFO is empty and decode is ready goes straight to id_* in the
// same cycle instead of being written into the FIFO.
// ---------------------------------------------------------------------------
module ysyx_23060072_if_prefetch #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h8000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [31:0]              imem_req_addr,
  input  logic                     imem_resp_valid,
  input  logic [31:0]              imem_resp_data,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [31:0]              id_pc,
  output logic [31:0]              id_inst,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]   r_fetch_pc;
  logic [OW-1:0] r_outstanding;
  logic [OW-1:0] r_drop_cnt;

  logic [31:0]   r_tag_q [MAX_OUTSTANDING];
  logic [TW-1:0] r_tag_wptr;
  logic [TW-1:0] r_tag_rptr;

  logic [31:0]   r_fifo_pc   [DEPTH];
  logic [31:0]   r_fifo_inst [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic          w_req_fire;
  logic          w_resp_live;
  logic          w_fifo_empty;
  logic          w_bypass;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_tag_head;
  logic          w_unused_rpc;

  // Tag queue pointer advance; MAX_OUTSTANDING need not be a power of two.
  function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
    return (32'(p) == MAX_OUTSTANDING - 1) ? '0 : p + TW'(1);
  endfunction

  assign w_unused_rpc = ^redirect_pc[1:0];
  assign w_tag_head   = r_tag_q[r_tag_rptr];
  assign w_req_fire   = imem_req_valid && imem_req_ready;
  assign w_resp_live  = imem_resp_valid && (r_drop_cnt == '0);
  assign w_fifo_empty = (r_count == '0);

`ifdef YSYX_23060072_PREFETCH_BYPASS_EN
  assign w_bypass = !rst && w_fifo_empty && w_resp_live && id_ready && !redirect_valid;
`else
  assign w_bypass = 1'b0;
`endif

  // A redirect discards both the same-cycle push and pop.
  assign w_push = w_resp_live && !redirect_valid && !w_bypass;
  assign w_pop  = !w_fifo_empty && !redirect_valid && id_ready;

  assign imem_req_addr = r_fetch_pc;
  assign fifo_count    = r_count;

  // Request credit and decode-side presentation.
  always_comb begin
    imem_req_valid = !rst && !redirect_valid
                     && (32'(r_outstanding) < MAX_OUTSTANDING)
                     && ((32'(r_count) + 32'(r_outstanding) - 32'(r_drop_cnt)) < DEPTH);
    id_valid       = !w_fifo_empty && !redirect_valid;
    id_pc          = w_fifo_empty ? '0 : r_fifo_pc[r_rptr];
    id_inst        = w_fifo_empty ? '0 : r_fifo_inst[r_rptr];
    if (w_bypass) begin
      id_valid = 1'b1;
      id_pc    = w_tag_head;
      id_inst  = imem_resp_data;
    end
  end

  // Fetch PC, in-flight and drop accounting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      if (redirect_valid) begin
        r_fetch_pc <= {redirect_pc[31:2], 2'b00};
        // Everything still in flight after this cycle's response is stale.
        r_drop_cnt <= r_outstanding - OW'(imem_resp_valid);
      end else begin
        if (w_req_fire) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (imem_resp_valid && (r_drop_cnt != '0)) begin
          r_drop_cnt <= r_drop_cnt - OW'(1);
        end
      end
      r_outstanding <= r_outstanding + OW'(w_req_fire) - OW'(imem_resp_valid);
    end
  end

  // Tag queue pointers; entries survive redirects so stale responses still pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_wptr <= '0;
      r_tag_rptr <= '0;
    end else begin
      if (w_req_fire) begin
        r_tag_wptr <= tag_next(r_tag_wptr);
      end
      if (imem_resp_valid) begin
        r_tag_rptr <= tag_next(r_tag_rptr);
      end
    end
  end

  // Tag queue storage.
  always_ff @(posedge clk) begin
    if (w_req_fire) begin
      r_tag_q[r_tag_wptr] <= r_fetch_pc;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (redirect_valid) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wptr]   <= w_tag_head;
      r_fifo_inst[r_wptr] <= imem_resp_data;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(imem_resp_valid && (r_outstanding == '0)));
      assert (!(w_push && !w_pop && (32'(r_count) == DEPTH)));
    end
  end
`endif

endmodule
